long_mul_unit: RTL and testbench

- Iterative multicycle 32x32->64 multiplier for UMULL/SMULL/UMLAL/SMLAL.
- It is the producer side of the register file's dual-write interface: it drives the RdLo/RdHi addresses, the two data words and the 64-bit write qualifier.
- It sits between the decoder/control FSM (start handshake) and regfile writeback.

---
 rtl/arm_mul_pkg.sv | 16 +
 rtl/long_mul_core.sv | 66 ++++++
 rtl/long_mul_unit.sv | 177 +++++++++++++++++
 tb/tb_long_mul_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/arm_mul_pkg.sv
// Shared types and sizing for the long multiply unit.
// Build option LONG_MUL_EARLY_TERM_EN is consumed by long_mul_core.
package arm_mul_pkg;

    localparam int MUL_WIDTH = 32;
    localparam int REG_IDX_W = 4;
    localparam int CNT_W     = $clog2(MUL_WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mul_state_e;

endpackage

// File: rtl/long_mul_core.sv
// Radix-2 shift-add datapath: multiplicand/multiplier shift registers, 2*WIDTH accumulator, step counter.
// One multiplier bit per step, LSB first; 'last' flags the final step (LONG_MUL_EARLY_TERM_EN: also when the remaining multiplier bits are zero).
module long_mul_core
    import arm_mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 last
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (load) begin
            mcand_d  = {{WIDTH{1'b0}}, op_a};
            mplier_d = op_b;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (step) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    // 'last' describes the step being taken this cycle, so the FSM can leave CALC on the same edge.
`ifdef LONG_MUL_EARLY_TERM_EN
    assign last = (cnt_q == CW'(WIDTH - 1)) || (mplier_q[WIDTH-1:1] == '0);
`else
    assign last = (cnt_q == CW'(WIDTH - 1));
`endif

    assign product = acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/long_mul_unit.sv
// Iterative UMULL/SMULL/UMLAL/SMLAL unit driving the regfile dual-write port; latency WIDTH+2 cycles.
// Build option LONG_MUL_EARLY_TERM_EN makes latency variable (3..WIDTH+2); start is ignored while busy.
module long_mul_unit
    import arm_mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  is_signed,
    input  logic                  accumulate,
    input  logic [WIDTH-1:0]      op_a,
    input  logic [WIDTH-1:0]      op_b,
    input  logic [WIDTH-1:0]      acc_lo,
    input  logic [WIDTH-1:0]      acc_hi,
    input  logic [REG_IDX_W-1:0]  rd_lo,
    input  logic [REG_IDX_W-1:0]  rd_hi,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      res_lo,
    output logic [WIDTH-1:0]      res_hi,
    output logic [REG_IDX_W-1:0]  wa3_32,
    output logic [REG_IDX_W-1:0]  wa3_64,
    output logic                  Src_64b,
    output logic                  flag_n,
    output logic                  flag_z
);

    mul_state_e           state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 sign_q, sign_d;
    logic                 accum_q, accum_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [REG_IDX_W-1:0] rd_lo_q, rd_lo_d;
    logic [REG_IDX_W-1:0] rd_hi_q, rd_hi_d;
    logic [REG_IDX_W-1:0] wa_lo_q, wa_lo_d;
    logic [REG_IDX_W-1:0] wa_hi_q, wa_hi_d;
    logic [WIDTH-1:0]     res_lo_q, res_lo_d;
    logic [WIDTH-1:0]     res_hi_q, res_hi_d;
    logic                 flag_n_q, flag_n_d;
    logic                 flag_z_q, flag_z_d;

    logic                 core_load;
    logic                 core_step;
    logic                 core_last;
    logic [2*WIDTH-1:0]   product;
    logic [2*WIDTH-1:0]   fix_val;
    logic [WIDTH-1:0]     a_abs;
    logic [WIDTH-1:0]     b_abs;

    // The most negative value negates to itself, which is its correct magnitude read as unsigned.
    assign a_abs = (is_signed && op_a[WIDTH-1]) ? (~op_a + 1'b1) : op_a;
    assign b_abs = (is_signed && op_b[WIDTH-1]) ? (~op_b + 1'b1) : op_b;

    long_mul_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .rst_n   (reset),
        .load    (core_load),
        .step    (core_step),
        .op_a    (a_abs),
        .op_b    (b_abs),
        .product (product),
        .last    (core_last)
    );

    always_comb begin
        fix_val = sign_q ? (~product + 1'b1) : product;
        if (accum_q) begin
            fix_val = fix_val + acc_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = done_q;
        sign_d    = sign_q;
        accum_d   = accum_q;
        acc_d     = acc_q;
        rd_lo_d   = rd_lo_q;
        rd_hi_d   = rd_hi_q;
        wa_lo_d   = wa_lo_q;
        wa_hi_d   = wa_hi_q;
        res_lo_d  = res_lo_q;
        res_hi_d  = res_hi_q;
        flag_n_d  = flag_n_q;
        flag_z_d  = flag_z_q;
        core_load = 1'b0;
        core_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    core_load = 1'b1;
                    sign_d    = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    accum_d   = accumulate;
                    acc_d     = {acc_hi, acc_lo};
                    rd_lo_d   = rd_lo;
                    rd_hi_d   = rd_hi;
                    busy_d    = 1'b1;
                    state_d   = ST_CALC;
                end
            end
            ST_CALC: begin
                core_step = 1'b1;
                if (core_last) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                res_lo_d = fix_val[WIDTH-1:0];
                res_hi_d = fix_val[2*WIDTH-1:WIDTH];
                flag_n_d = fix_val[2*WIDTH-1];
                flag_z_d = (fix_val == '0);
                wa_lo_d  = rd_lo_q;
                wa_hi_d  = rd_hi_q;
                done_d   = 1'b1;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sign_q   <= 1'b0;
            accum_q  <= 1'b0;
            acc_q    <= '0;
            rd_lo_q  <= '0;
            rd_hi_q  <= '0;
            wa_lo_q  <= '0;
            wa_hi_q  <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sign_q   <= sign_d;
            accum_q  <= accum_d;
            acc_q    <= acc_d;
            rd_lo_q  <= rd_lo_d;
            rd_hi_q  <= rd_hi_d;
            wa_lo_q  <= wa_lo_d;
            wa_hi_q  <= wa_hi_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            flag_n_q <= flag_n_d;
            flag_z_q <= flag_z_d;
        end
    end

    // When rd_lo == rd_hi the regfile commits wa3_64 after wa3_32, so the high word lands.
    assign busy    = busy_q;
    assign done    = done_q;
    assign Src_64b = done_q;
    assign res_lo  = res_lo_q;
    assign res_hi  = res_hi_q;
    assign wa3_32  = wa_lo_q;
    assign wa3_64  = wa_hi_q;
    assign flag_n  = flag_n_q;
    assign flag_z  = flag_z_q;

endmodule

// File: tb/tb_long_mul_unit.sv
// Scoreboard bench for long_mul_unit: stimulus pushes model results, a done-driven monitor pops and compares.
module tb_long_mul_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          is_signed = 1'b0;
    logic          accumulate = 1'b0;
    logic [W-1:0]  op_a = '0;
    logic [W-1:0]  op_b = '0;
    logic [W-1:0]  acc_lo = '0;
    logic [W-1:0]  acc_hi = '0;
    logic [3:0]    rd_lo = '0;
    logic [3:0]    rd_hi = '0;
    logic          busy, done, Src_64b, flag_n, flag_z;
    logic [W-1:0]  res_lo, res_hi;
    logic [3:0]    wa3_32, wa3_64;

    typedef struct {
        logic [63:0] val;
        logic [3:0]  wlo;
        logic [3:0]  whi;
    } exp_t;

    exp_t sb_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    long_mul_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .accumulate(accumulate), .op_a(op_a), .op_b(op_b), .acc_lo(acc_lo),
        .acc_hi(acc_hi), .rd_lo(rd_lo), .rd_hi(rd_hi), .busy(busy), .done(done),
        .res_lo(res_lo), .res_hi(res_hi), .wa3_32(wa3_32), .wa3_64(wa3_64),
        .Src_64b(Src_64b), .flag_n(flag_n), .flag_z(flag_z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: plain 64-bit arithmetic on the architectural operand values.
    function automatic logic [63:0] model(input bit s, input bit ac, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] acc);
        logic [63:0] ea, eb, p;
        ea = s ? {{32{a[31]}}, a} : {32'b0, a};
        eb = s ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        if (ac) p = p + acc;
        return p;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("res", {res_hi, res_lo}, e.val);
                chk("wa3_32", 64'(wa3_32), 64'(e.wlo));
                chk("wa3_64", 64'(wa3_64), 64'(e.whi));
                chk("flag_n", 64'(flag_n), 64'(e.val[63]));
                chk("flag_z", 64'(flag_z), 64'(e.val == 64'd0));
                chk("src_64b", 64'(Src_64b), 64'd1);
            end
        end
    end

    task automatic do_op(input bit s, input bit ac, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] acc, input logic [3:0] rl, input logic [3:0] rh,
                         input bit inject, output int lat);
        exp_t e;
        int   n;
        bit   seen, busy_ok;
        @(negedge clk);
        is_signed = s; accumulate = ac; op_a = a; op_b = b;
        acc_lo = acc[31:0]; acc_hi = acc[63:32]; rd_lo = rl; rd_hi = rh; start = 1'b1;
        e.val = model(s, ac, a, b, acc); e.wlo = rl; e.whi = rh;
        sb_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_on_accept", 64'(busy), 64'd1);
        // Inputs after acceptance must not matter.
        op_a = $urandom; op_b = $urandom; acc_lo = $urandom; acc_hi = $urandom;
        is_signed = 1'($urandom); accumulate = 1'($urandom);
        rd_lo = 4'($urandom); rd_hi = 4'($urandom);
        n = 0; seen = 0; busy_ok = 1;
        while (n < 40 && !seen) begin
            if (inject) start = (n == 4 || n == 5 || n == 32);
            @(posedge clk); #1;
            n++;
            if (done) seen = 1;
            else if (!busy) busy_ok = 0;
        end
        // With inject, start stays high across the DONE cycle as well.
        chk("done_seen", 64'(seen), 64'd1);
        chk("busy_continuous", 64'(busy_ok), 64'd1);
        lat = n + 1;  // cycles counted from the cycle that drove start
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("src_one_cycle", 64'(Src_64b), 64'd0);
        chk("res_hold", {res_hi, res_lo}, e.val);
    endtask

    task automatic chk_lat(input int lat);
`ifdef LONG_MUL_EARLY_TERM_EN
        chk("latency_range", 64'(lat >= 3 && lat <= W + 2), 64'd1);
`else
        chk("latency", 64'(lat), 64'(W + 2));
`endif
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int lat;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_src", 64'(Src_64b), 64'd0);
        chk("rst_res", {res_hi, res_lo}, 64'd0);
        chk("rst_wa", 64'({wa3_64, wa3_32}), 64'd0);
        chk("rst_flags", 64'({flag_n, flag_z}), 64'd0);
        @(negedge clk); reset = 1'b1;

        do_op(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 4'd1, 4'd2, 0, lat);
        chk_lat(lat);
        chk("umull_ff_value", {res_hi, res_lo}, 64'hFFFF_FFFE_0000_0001);
        do_op(1, 0, 32'hFFFF_FFFE, 32'h0000_0003, 64'd0, 4'd3, 4'd5, 0, lat);
        chk("smull_neg", {res_hi, res_lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        do_op(1, 0, 32'h8000_0000, 32'h8000_0000, 64'd0, 4'd6, 4'd7, 0, lat);
        chk("smull_min", {res_hi, res_lo}, 64'h4000_0000_0000_0000);
        do_op(0, 1, 32'd2, 32'd3, 64'h0000_0000_FFFF_FFFF, 4'd8, 4'd9, 0, lat);
        chk("umlal_carry", {res_hi, res_lo}, 64'h0000_0001_0000_0005);
        do_op(1, 1, 32'd0, 32'd5, 64'd0, 4'd10, 4'd11, 0, lat);
        chk("smlal_zero_flag", 64'(flag_z), 64'd1);
        do_op(0, 0, 32'd1, 32'd1, 64'd0, 4'd4, 4'd4, 0, lat);
        chk("same_idx_wa", 64'({wa3_64, wa3_32}), 64'h44);
`ifdef LONG_MUL_EARLY_TERM_EN
        chk("early_term_b1", 64'(lat <= 4), 64'd1);
`endif

        // Starts during CALC, FIX and DONE are ignored; the next op starts right after done drops.
        do_op(0, 0, 32'h1234_5678, 32'h8000_0001, 64'd0, 4'd12, 4'd13, 1, lat);
        chk_lat(lat);
        do_op(1, 1, 32'hDEAD_BEEF, 32'h8765_4321, 64'h0123_4567_89AB_CDEF, 4'd14, 4'd15, 0, lat);
        chk_lat(lat);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        op_a = 32'h0000_FFFF; op_b = 32'h8000_0003; is_signed = 0; accumulate = 0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #3; reset = 1'b0; #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_res", {res_hi, res_lo}, 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        @(negedge clk); reset = 1'b1;
        repeat (40) @(posedge clk);
        #1 chk("arst_idle_busy", 64'(busy), 64'd0);
        do_op(0, 0, 32'd7, 32'd9, 64'd0, 4'd2, 4'd3, 0, lat);
        chk_lat(lat);

        for (int i = 0; i < 20; i++) begin
            do_op(1'($urandom), 1'($urandom), pick(), pick(), {pick(), pick()},
                  4'($urandom), 4'($urandom), 0, lat);
            chk_lat(lat);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
